// File: rtl/compressor_pkg.sv
// Shared definitions for the run-length compressor.
// Holds the default word/run-length widths and the controller state encoding.
package compressor_pkg;

    localparam int unsigned N_DEFAULT = 32;
    localparam int unsigned W_DEFAULT = $clog2(N_DEFAULT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/compressor_run_length_finder.sv
// run_length_finder: purely combinational run measurement.
// Ports:
//   word    - word being scanned
//   pos     - bit index where the run starts (0..N-1)
//   run_bit - value of word[pos]
//   run_len - number of consecutive bits equal to run_bit from pos upward,
//             bounded by the end of the word (1..N)
module run_length_finder
    import compressor_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [N-1:0] word,
    input  logic [W-1:0] pos,
    output logic         run_bit,
    output logic [W-1:0] run_len
);

    logic [N-1:0] shifted;

    // Equality mask from pos, then a priority encoder on the first break;
    // positions past the end of the word count as a break.
    always_comb begin
        shifted = word >> pos;
        run_bit = shifted[0];
        run_len = W'(N);
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if ((shifted[i] != run_bit) || ((i + int'(pos)) >= int'(N))) begin
                run_len = W'(i);
            end
        end
    end

endmodule

// File: rtl/compressor.sv
// compressor: run-length encoder, one run found per SCAN cycle, bit 0 first.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   in_valid/in_ready     - word handshake, in_data holds the word
//   flush                 - emit any pending run and clear it
//   out_valid/out_ready   - run handshake, out_bit/out_value hold the run
//   busy                  - SCAN or FLUSH active, or a run is still held
// Build option: COMPRESSOR_MERGE_EN lets runs merge across word boundaries;
// without it the pending run is emitted at the end of every word.
module compressor
    import compressor_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    parameter int unsigned W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic [W-1:0] out_value,
    output logic         busy
);

    // One extra bit so pending_len + run_len (up to 2N) cannot wrap.
    localparam int unsigned SW = W + 1;

    state_t         state, state_n;
    logic [N-1:0]   word_q, word_n;
    logic [W-1:0]   pos_q, pos_n;
    logic           pend_valid_q, pend_valid_n;
    logic           pend_bit_q, pend_bit_n;
    logic [W-1:0]   pend_len_q, pend_len_n;
    logic           out_valid_n, out_bit_n;
    logic [W-1:0]   out_value_n;

    logic           run_bit;
    logic [W-1:0]   run_len;
    logic           out_free, same_bit, need_emit;
    logic [SW-1:0]  sum, rem, pos_sum;
    logic           emit_bit;
    logic [W-1:0]   emit_len;
    logic           step_pv, step_pb;
    logic [W-1:0]   step_pl;

    run_length_finder #(.N(N), .W(W)) u_finder (
        .word    (word_q),
        .pos     (pos_q),
        .run_bit (run_bit),
        .run_len (run_len)
    );

    // Result of one SCAN step: what to emit and the new pending run.
    always_comb begin
        out_free  = !out_valid || out_ready;
        same_bit  = pend_valid_q && (pend_bit_q == run_bit);
        sum       = (same_bit ? SW'(pend_len_q) : SW'(0)) + SW'(run_len);
        rem       = sum - SW'(N);
        pos_sum   = SW'(pos_q) + SW'(run_len);
        need_emit = 1'b0;
        emit_bit  = run_bit;
        emit_len  = W'(N);
        step_pv   = 1'b1;
        step_pb   = run_bit;
        step_pl   = run_len;
        if (pend_valid_q && !same_bit) begin
            // Bit changed: the old run is complete.
            need_emit = 1'b1;
            emit_bit  = pend_bit_q;
            emit_len  = pend_len_q;
        end else if (sum >= SW'(N)) begin
            // A full-length run is ready; keep only the overflow.
            need_emit = 1'b1;
            step_pv   = (rem != '0);
            step_pl   = W'(rem);
        end else begin
            step_pl   = W'(sum);
        end
    end

    // Next-state and output-register loading.
    always_comb begin
        state_n      = state;
        word_n       = word_q;
        pos_n        = pos_q;
        pend_valid_n = pend_valid_q;
        pend_bit_n   = pend_bit_q;
        pend_len_n   = pend_len_q;
        out_valid_n  = out_valid && !out_ready;
        out_bit_n    = out_bit;
        out_value_n  = out_value;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    word_n  = in_data;
                    pos_n   = '0;
                    state_n = SCAN;
                end else if (flush && pend_valid_q) begin
                    state_n = FLUSH;
                end
            end
            SCAN: begin
                // An emit with a full output register stalls the whole step.
                if (!need_emit || out_free) begin
                    pend_valid_n = step_pv;
                    pend_bit_n   = step_pb;
                    pend_len_n   = step_pl;
                    pos_n        = W'(pos_sum);
                    if (need_emit) begin
                        out_valid_n = 1'b1;
                        out_bit_n   = emit_bit;
                        out_value_n = emit_len;
                    end
                    if (pos_sum == SW'(N)) begin
`ifdef COMPRESSOR_MERGE_EN
                        state_n = IDLE;
`else
                        state_n = step_pv ? FLUSH : IDLE;
`endif
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    out_valid_n  = 1'b1;
                    out_bit_n    = pend_bit_q;
                    out_value_n  = pend_len_q;
                    pend_valid_n = 1'b0;
                    pend_bit_n   = 1'b0;
                    pend_len_n   = '0;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            word_q       <= '0;
            pos_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_bit_q   <= 1'b0;
            pend_len_q   <= '0;
            out_valid    <= 1'b0;
            out_bit      <= 1'b0;
            out_value    <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            word_q       <= word_n;
            pos_q        <= pos_n;
            pend_valid_q <= pend_valid_n;
            pend_bit_q   <= pend_bit_n;
            pend_len_q   <= pend_len_n;
            out_valid    <= out_valid_n;
            out_bit      <= out_bit_n;
            out_value    <= out_value_n;
            in_ready     <= (state_n == IDLE);
            busy         <= (state_n != IDLE) || out_valid_n;
        end
    end

endmodule

// File: tb/tb_compressor.sv
// Self-checking bench for compressor (N=32). Expected runs come from a
// bit-stream model: split the input bits into maximal runs, then cut each run
// into pieces of at most N (merge build: whole stream; otherwise per word).
module tb_compressor;

    localparam int unsigned N = 32;
    localparam int unsigned W = $clog2(N) + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_bit;
    logic [W-1:0] out_value;
    logic         busy;

    int           vectors = 0;
    int           miscompares = 0;
    bit           rnd_ready = 1'b0;
    int           got[$];
    int           exp_q[$];
    logic [N-1:0] words_q[$];

    compressor #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_value (out_value),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle: record a handshake at negedge, return 1 time unit after posedge.
    task automatic tick();
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1)
            got.push_back((int'(out_bit) << 8) | int'(out_value));
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_word(input logic [N-1:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 300) begin tick(); n++; end
        if (in_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL send_word timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        int n = 0;
        while (in_ready !== 1'b1 && n < 300) begin tick(); n++; end
        if (in_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL flush timeout: in_ready=%0b required 1", in_ready);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || in_ready !== 1'b1) && n < 600) begin tick(); n++; end
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL idle timeout: busy=%0b in_ready=%0b required 0/1", busy, in_ready);
        end
    endtask

    // Reference: runs of the bit stream in words_q, cut into pieces of <= N.
    function automatic void build_expected();
        int b, r, c, bi;
        logic [N-1:0] w;
        exp_q.delete();
        b = 0; r = 0;
        foreach (words_q[k]) begin
`ifndef COMPRESSOR_MERGE_EN
            while (r > 0) begin
                c = (r > int'(N)) ? int'(N) : r;
                exp_q.push_back((b << 8) | c); r -= c;
            end
`endif
            w = words_q[k];
            for (int i = 0; i < int'(N); i++) begin
                bi = int'(w[i]);
                if (r > 0 && bi == b) r++;
                else begin
                    while (r > 0) begin
                        c = (r > int'(N)) ? int'(N) : r;
                        exp_q.push_back((b << 8) | c); r -= c;
                    end
                    b = bi; r = 1;
                end
            end
        end
        while (r > 0) begin
            c = (r > int'(N)) ? int'(N) : r;
            exp_q.push_back((b << 8) | c); r -= c;
        end
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %0b required 0", out_valid); end
        vectors++;
        if (out_bit !== 1'b0) begin miscompares++; $display("FAIL reset out_bit: got %0b required 0", out_bit); end
        vectors++;
        if (out_value !== '0) begin miscompares++; $display("FAIL reset out_value: got %0d required 0", out_value); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %0b required 0", busy); end
        reset = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %0b required 1", in_ready); end
        tick();
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL idle after reset: in_ready=%0b busy=%0b required 1/0", in_ready, busy);
        end
    endtask

    // Directed words: all-zero, half/half, cross-word merge, two all-one words.
    task automatic test_patterns();
        logic [N-1:0] wa[4], wb[4];
        int nw[4], pre[4], post[4];
        int start, a;
        wa = '{32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF};
        wb = '{32'h0, 32'h0, 32'h0000_00FF, 32'hFFFF_FFFF};
        nw = '{1, 1, 2, 2};
`ifdef COMPRESSOR_MERGE_EN
        pre  = '{1, 1, 2, 2};
        post = '{1, 2, 3, 2};
`else
        pre  = '{1, 2, 4, 2};
        post = '{1, 2, 4, 2};
`endif
        for (int s = 0; s < 4; s++) begin
            start = got.size();
            words_q.delete();
            words_q.push_back(wa[s]);
            if (nw[s] == 2) words_q.push_back(wb[s]);
            send_word(wa[s]);
            if (s == 0) begin
                tick();
                vectors++;
                if ({out_valid, out_bit, out_value} !== {1'b1, 1'b0, W'(32)}) begin
                    miscompares++;
                    $display("FAIL zero-word latency: valid=%0b bit=%0b len=%0d required 1/0/32", out_valid, out_bit, out_value);
                end
            end
            if (nw[s] == 2) send_word(wb[s]);
            wait_idle();
            vectors++;
            if (got.size() - start !== pre[s]) begin
                miscompares++; $display("FAIL pattern %0d runs before flush: got %0d required %0d", s, got.size() - start, pre[s]);
            end
            do_flush();
            wait_idle();
            vectors++;
            if (got.size() - start !== post[s]) begin
                miscompares++; $display("FAIL pattern %0d runs after flush: got %0d required %0d", s, got.size() - start, post[s]);
            end
            build_expected();
            for (int k = 0; k < exp_q.size(); k++) begin
                a = (start + k < got.size()) ? got[start + k] : 0;
                vectors++;
                if (a !== exp_q[k]) begin
                    miscompares++;
                    $display("FAIL pattern %0d run %0d: got bit=%0d len=%0d required bit=%0d len=%0d",
                             s, k, (a >> 8) & 1, a & 255, (exp_q[k] >> 8) & 1, exp_q[k] & 255);
                end
            end
        end
    endtask

    // Alternating word with the consumer stalled for five cycles mid-word.
    task automatic test_backpressure();
        int start, a;
        start = got.size();
        words_q.delete();
        words_q.push_back(32'hAAAA_AAAA);
        send_word(32'hAAAA_AAAA);
        tick(); tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({out_valid, out_bit, out_value, busy} !== {1'b1, 1'b0, W'(1), 1'b1}) begin
                miscompares++;
                $display("FAIL stall hold %0d: valid=%0b bit=%0b len=%0d busy=%0b required 1/0/1/1", c, out_valid, out_bit, out_value, busy);
            end
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        do_flush();
        wait_idle();
        build_expected();
        vectors++;
        if (got.size() - start !== 32 || exp_q.size() !== 32) begin
            miscompares++; $display("FAIL stall run count: got %0d required 32", got.size() - start);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            a = (start + k < got.size()) ? got[start + k] : 0;
            vectors++;
            if (a !== exp_q[k]) begin
                miscompares++;
                $display("FAIL stall run %0d: got bit=%0d len=%0d required bit=%0d len=%0d",
                         k, (a >> 8) & 1, a & 255, (exp_q[k] >> 8) & 1, exp_q[k] & 255);
            end
        end
    endtask

    // Reset during a SCAN discards the partial word and the pending run.
    task automatic test_mid_reset();
        int start, a;
        send_word(32'h00FF_00FF);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL mid-reset state: valid=%0b in_ready=%0b busy=%0b required 0/1/0", out_valid, in_ready, busy);
        end
        start = got.size();
        send_word(32'hFFFF_FFFF);
        wait_idle();
        do_flush();
        wait_idle();
        vectors++;
        a = (got.size() > start) ? got[start] : 0;
        if (got.size() - start !== 1 || a !== ((1 << 8) | 32)) begin
            miscompares++;
            $display("FAIL post-reset word: got %0d runs first bit=%0d len=%0d required 1 run bit=1 len=32",
                     got.size() - start, (a >> 8) & 1, a & 255);
        end
    endtask

    // Back-to-back random words with random consumer stalls.
    task automatic test_random();
        int start, a, nwords, sh;
        logic [N-1:0] w;
        rnd_ready = 1'b1;
        for (int seg = 0; seg < 8; seg++) begin
            start = got.size();
            words_q.delete();
            nwords = $urandom_range(1, 4);
            for (int i = 0; i < nwords; i++) begin
                sh = $urandom_range(0, int'(N) - 1);
                w = '1;
                case ($urandom_range(0, 4))
                    0: w = N'($urandom);
                    1: w = '0;
                    2: w = '1;
                    3: w = w << sh;
                    default: w = w >> sh;
                endcase
                words_q.push_back(w);
                send_word(w);
            end
            do_flush();
            wait_idle();
            build_expected();
            vectors++;
            if (got.size() - start !== exp_q.size()) begin
                miscompares++; $display("FAIL random seg %0d run count: got %0d required %0d", seg, got.size() - start, exp_q.size());
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                a = (start + k < got.size()) ? got[start + k] : 0;
                vectors++;
                if (a !== exp_q[k]) begin
                    miscompares++;
                    $display("FAIL random seg %0d run %0d: got bit=%0d len=%0d required bit=%0d len=%0d",
                             seg, k, (a >> 8) & 1, a & 255, (exp_q[k] >> 8) & 1, exp_q[k] & 255);
                end
            end
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
